seq_step_counter: RTL and testbench



---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_lfsr.sv | 32 +++
 rtl/seq_step_counter.sv | 153 +++++++++++++++
 tb/tb_seq_step_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player step logic: mode encodings and LFSR constants.
package seq_pkg;

   typedef enum logic [1:0] {
      MODE_FWD      = 2'b00,
      MODE_REV      = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_RANDOM   = 2'b11
   } seq_mode_e;

   localparam int LFSR_W = 16;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/seq_lfsr.sv
// 16-bit Galois LFSR with advance and seed reload; sample exposes the low bits of the value
// the register takes on the next advance.
module seq_lfsr
   import seq_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
   parameter int unsigned       OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             reload,
   output logic [OUT_W-1:0] sample
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_next;

   assign state_next = lfsr_step(state_q);
   assign sample     = state_next[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else if (reload) begin
         state_q <= SEED;
      end else if (advance) begin
         state_q <= state_next;
      end
   end

endmodule

// File: rtl/seq_step_counter.sv
// Sequencer step index generator with forward/reverse/ping-pong/random traversal.
// Random mode is built only when SEQ_RANDOM_MODE_EN is defined; otherwise mode 11 runs forward.
module seq_step_counter
   import seq_pkg::*;
#(
   parameter int unsigned       STEP_W    = 4,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              hold,
   input  logic              restart,
   input  logic [STEP_W-1:0] last_step,
   input  logic [1:0]        mode,
   output logic [STEP_W-1:0] step,
   output logic              wrap,
   output logic              dir_down
);

   localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

   logic [STEP_W-1:0] step_q, step_d;
   logic              wrap_q, wrap_d;
   logic              dir_q, dir_d;
   logic              adv;
   seq_mode_e         eff_mode;

   assign adv      = enable & ~hold & ~restart;
   assign step     = step_q;
   assign wrap     = wrap_q;
   assign dir_down = dir_q;

   always_comb begin
      eff_mode = seq_mode_e'(mode);
`ifndef SEQ_RANDOM_MODE_EN
      if (eff_mode == MODE_RANDOM) eff_mode = MODE_FWD;
`endif
   end

`ifdef SEQ_RANDOM_MODE_EN
   logic [STEP_W-1:0] pass_q, pass_d;
   logic [STEP_W-1:0] rnd_sample, rnd_fold;
   logic              lfsr_adv;

   // Smallest all-ones value covering v, so the fold needs at most one subtraction.
   function automatic logic [STEP_W-1:0] fill_mask(input logic [STEP_W-1:0] v);
      logic [STEP_W-1:0] m;
      m = v;
      for (int i = 1; i < int'(STEP_W); i = i * 2) m = m | (m >> i);
      return m;
   endfunction

   assign lfsr_adv = adv && (eff_mode == MODE_RANDOM);
   assign rnd_fold = rnd_sample & fill_mask(last_step);

   seq_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (STEP_W)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (lfsr_adv),
      .reload  (restart),
      .sample  (rnd_sample)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pass_q <= '0;
      else        pass_q <= pass_d;
   end
`endif

   always_comb begin
      step_d = step_q;
      wrap_d = 1'b0;
      dir_d  = (eff_mode == MODE_PINGPONG) ? dir_q : 1'b0;
`ifdef SEQ_RANDOM_MODE_EN
      pass_d = (eff_mode == MODE_RANDOM) ? pass_q : '0;
`endif
      if (restart) begin
         step_d = (eff_mode == MODE_REV) ? last_step : '0;
         dir_d  = 1'b0;
`ifdef SEQ_RANDOM_MODE_EN
         pass_d = '0;
`endif
      end else if (adv) begin
         case (eff_mode)
            MODE_REV: begin
               if (step_q == '0 || step_q > last_step) begin
                  step_d = last_step;
                  wrap_d = 1'b1;
               end else begin
                  step_d = step_q - ONE;
               end
            end
            MODE_PINGPONG: begin
               if (last_step == '0) begin
                  step_d = '0;
                  dir_d  = 1'b0;
                  wrap_d = 1'b1;
               end else if (step_q > last_step) begin
                  step_d = last_step;
                  dir_d  = 1'b1;
               end else if (dir_q && step_q > ONE) begin
                  step_d = step_q - ONE;
               end else if (dir_q || step_q == last_step) begin
                  // Turning down from the top, or arriving back at step 0.
                  step_d = step_q - ONE;
                  dir_d  = (step_q != ONE);
                  wrap_d = (step_q == ONE);
               end else begin
                  // Direction flips on arrival at the top so dir_down shows the next move.
                  step_d = step_q + ONE;
                  dir_d  = (step_q + ONE == last_step);
               end
            end
`ifdef SEQ_RANDOM_MODE_EN
            MODE_RANDOM: begin
               step_d = (rnd_fold <= last_step) ? rnd_fold : rnd_fold - last_step - ONE;
               if (pass_q >= last_step) begin
                  pass_d = '0;
                  wrap_d = 1'b1;
               end else begin
                  pass_d = pass_q + ONE;
               end
            end
`endif
            default: begin
               if (step_q >= last_step) begin
                  step_d = '0;
                  wrap_d = 1'b1;
               end else begin
                  step_d = step_q + ONE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
         wrap_q <= 1'b0;
         dir_q  <= 1'b0;
      end else begin
         step_q <= step_d;
         wrap_q <= wrap_d;
         dir_q  <= dir_d;
      end
   end

endmodule

// File: tb/tb_seq_step_counter.sv
// Table-driven bench for seq_step_counter with a queue scoreboard; random-mode vectors
// are generated from a reference LFSR model when SEQ_RANDOM_MODE_EN is defined.
module tb_seq_step_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         hold = 1'b0;
   logic         restart = 1'b0;
   logic [W-1:0] last_step = '0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] step;
   logic         wrap;
   logic         dir_down;

   seq_step_counter #(
      .STEP_W    (W),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .hold      (hold),
      .restart   (restart),
      .last_step (last_step),
      .mode      (mode),
      .step      (step),
      .wrap      (wrap),
      .dir_down  (dir_down)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         do_rst;
      logic [7:0]   seg;
      logic         rs;
      logic         hd;
      logic         en;
      logic [W-1:0] ls;
      logic [1:0]   md;
      logic [W-1:0] e_step;
      logic         e_wrap;
      logic         e_dir;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] s;
      logic         w;
      logic         d;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   int pp_s[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
   int pp_d[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
   int rv_s[4] = '{5, 4, 3, 2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic void add(input logic r, input int seg, input logic rs, input logic hd,
                               input logic en, input int ls, input int md, input int es,
                               input logic ew, input logic ed);
      vec_t v;
      v.do_rst = r;
      v.seg    = 8'(seg);
      v.rs     = rs;
      v.hd     = hd;
      v.en     = en;
      v.ls     = W'(ls);
      v.md     = 2'(md);
      v.e_step = W'(es);
      v.e_wrap = ew;
      v.e_dir  = ed;
      vecs.push_back(v);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      enable  = 1'b0;
      hold    = 1'b0;
      restart = 1'b0;
      @(negedge clk);
      check("reset_step", 32'(step), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      check("reset_dir", 32'(dir_down), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t  e;
      string tag;
      if (v.do_rst) do_reset();
      @(negedge clk);
      restart   = v.rs;
      hold      = v.hd;
      enable    = v.en;
      last_step = v.ls;
      mode      = v.md;
      sb.push_back('{s: v.e_step, w: v.e_wrap, d: v.e_dir});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      tag = $sformatf("seg%0d_v%0d", v.seg, idx);
      check({tag, "_step"}, 32'(step), 32'(e.s));
      check({tag, "_wrap"}, 32'(wrap), 32'(e.w));
      check({tag, "_dir"}, 32'(dir_down), 32'(e.d));
   endtask

`ifdef SEQ_RANDOM_MODE_EN
   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ ({16{s[0]}} & 16'hB400);
   endfunction

   function automatic int ref_fold(input logic [15:0] s, input int ls);
      int m;
      int f;
      m = 0;
      while (m < ls) m = m * 2 + 1;
      f = int'(s[W-1:0]) & m;
      return (f <= ls) ? f : f - (ls + 1);
   endfunction
`endif

   initial begin
      // Forward, length 8: wrap after the 8th advance only.
      for (int i = 1; i <= 10; i++) add(i == 1, 1, 0, 0, 1, 7, 0, i % 8, i == 8, 0);
      add(0, 1, 0, 0, 0, 7, 0, 2, 0, 0);
      // Ping-pong over 0..3.
      for (int i = 0; i < 8; i++) add(i == 0, 2, 0, 0, 1, 3, 2, pp_s[i], i == 5, pp_d[i] != 0);
      // Reverse down to 2, restart+enable, then held enables.
      for (int i = 0; i < 4; i++) add(i == 0, 3, 0, 0, 1, 5, 1, rv_s[i], i == 0, 0);
      add(0, 3, 1, 0, 1, 5, 1, 5, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 3, 0, 1, 1, 5, 1, 5, 0, 0);
      // Forward at 6, length shrinks to 4.
      for (int i = 1; i <= 6; i++) add(i == 1, 4, 0, 0, 1, 7, 0, i, 0, 0);
      add(0, 4, 0, 0, 1, 3, 0, 0, 1, 0);
      add(0, 4, 0, 0, 0, 3, 0, 0, 0, 0);
      // Full 16-step range with natural wrap.
      for (int i = 1; i <= 15; i++) add(i == 1, 5, 0, 0, 1, 15, 0, i, 0, 0);
      add(0, 5, 0, 0, 1, 15, 0, 0, 1, 0);
      // Single-step sequence in reverse: wrap on every advance.
      for (int i = 0; i < 3; i++) add(i == 0, 6, 0, 0, 1, 0, 1, 0, 1, 0);
      // Mode changes mid-sequence.
      add(1, 7, 0, 0, 1, 5, 0, 1, 0, 0);
      add(0, 7, 0, 0, 1, 5, 0, 2, 0, 0);
      add(0, 7, 0, 0, 1, 5, 2, 3, 0, 0);
      add(0, 7, 0, 0, 1, 5, 2, 4, 0, 0);
      add(0, 7, 0, 0, 1, 5, 2, 5, 0, 1);
      add(0, 7, 0, 0, 1, 5, 0, 0, 1, 0);
      // Wrap pulse then hold: pulse still lasts one cycle.
      add(1, 10, 0, 0, 1, 0, 0, 0, 1, 0);
      add(0, 10, 0, 1, 1, 0, 0, 0, 0, 0);
`ifdef SEQ_RANDOM_MODE_EN
      begin
         logic [15:0] lf;
         int          pass;
         int          es;
         logic        ew;
         for (int r = 0; r < 2; r++) begin
            lf   = 16'hACE1;
            pass = 0;
            if (r == 1) add(0, 8, 1, 0, 0, 5, 3, 0, 0, 0);
            for (int i = 0; i < 24; i++) begin
               lf   = ref_lfsr(lf);
               es   = ref_fold(lf, 5);
               ew   = (pass == 5);
               pass = ew ? 0 : pass + 1;
               add(r == 0 && i == 0, 8, 0, 0, 1, 5, 3, es, ew, 0);
            end
         end
      end
`else
      for (int i = 1; i <= 24; i++) add(i == 1, 8, 0, 0, 1, 5, 3, i % 6, (i % 6) == 0, 0);
`endif
      // Climb to step 9 for the asynchronous reset check.
      for (int i = 1; i <= 9; i++) add(i == 1, 9, 0, 0, 1, 15, 0, i, 0, 0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_step", 32'(step), 32'd0);
      check("async_reset_wrap", 32'(wrap), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
